// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the RV32I multi-cycle controller.
// master = controller side, slave = datapath/memory side.
interface multicycle_control_if #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned STATE_WIDTH = 4
);
   logic [DATA_WIDTH-1:0]  instr;
   logic                   zero;
   logic                   mem_ready;
   logic                   mem_req;
   logic                   mem_write;
   logic                   adr_src;
   logic                   ir_write;
   logic                   pc_write;
   logic                   reg_write;
   logic [1:0]             imm_src;
   logic [1:0]             alu_src_a;
   logic [1:0]             alu_src_b;
   logic [2:0]             alu_control;
   logic [1:0]             result_src;
   logic                   illegal_instr;
   logic [STATE_WIDTH-1:0] state_dbg;

   modport master (
      input  instr, zero, mem_ready,
      output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             imm_src, alu_src_a, alu_src_b, alu_control, result_src,
             illegal_instr, state_dbg
   );

   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             imm_src, alu_src_a, alu_src_b, alu_control, result_src,
             illegal_instr, state_dbg
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: registered state, outputs decoded from
// state, instr, zero and (in memory states) mem_ready.
module multicycle_control #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned STATE_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.master bus
);
   typedef enum logic [STATE_WIDTH-1:0] {
      S_RESET, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB,
      S_MEM_WRITE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t     state_q, state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [2:0] alu_op;
   logic       alu_ok;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic       illegal_instr;
   logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
   logic [2:0] alu_control;
   logic       unused_instr;

   assign opcode       = bus.instr[6:0];
   assign funct3       = bus.instr[14:12];
   assign unused_instr = ^{bus.instr[DATA_WIDTH-1:31], bus.instr[29:15], bus.instr[11:7]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_RESET;
      else     state_q <= state_d;
   end

   always_comb begin
      alu_ok = 1'b1;
      case (funct3)
         3'b000:  alu_op = (state_q == S_EXEC_R && bus.instr[30]) ? ALU_SUB : ALU_ADD;
         3'b111:  alu_op = ALU_AND;
         3'b110:  alu_op = ALU_OR;
         3'b010:  alu_op = ALU_SLT;
         default: begin
            alu_op = ALU_ADD;
            alu_ok = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d       = state_q;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      imm_src       = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_control   = ALU_ADD;
      result_src    = 2'b00;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = (opcode == OP_JAL) ? 2'b11 : 2'b10;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
               OP_RTYPE:          state_d = S_EXEC_R;
               OP_ITYPE:          state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEM_ADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = (opcode == OP_LOAD) ? 2'b00 : 2'b01;
            state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (bus.mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_EXEC_R, S_EXEC_I: begin
            alu_src_a   = 2'b10;
            alu_src_b   = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
            alu_control = alu_op;
            state_d     = alu_ok ? S_ALU_WB : S_TRAP;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a   = 2'b10;
            alu_control = ALU_SUB;
            // instr[12] separates bne from beq, so it inverts the taken sense
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
               pc_write = bus.zero ^ bus.instr[12];
               state_d  = S_FETCH;
            end else begin
               state_d  = S_TRAP;
            end
         end
         S_JAL: begin
            pc_write  = 1'b1;
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            state_d   = S_ALU_WB;
         end
         S_TRAP:  illegal_instr = 1'b1;
         default: state_d = S_RESET;
      endcase
   end

   assign bus.mem_req       = mem_req;
   assign bus.mem_write     = mem_write;
   assign bus.adr_src       = adr_src;
   assign bus.ir_write      = ir_write;
   assign bus.pc_write      = pc_write;
   assign bus.reg_write     = reg_write;
   assign bus.imm_src       = imm_src;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.alu_control   = alu_control;
   assign bus.result_src    = result_src;
   assign bus.illegal_instr = illegal_instr;
   assign bus.state_dbg     = state_q;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I subset core (lw, sw, R-type ALU, I-type ALU, beq/bne, jal).
- Sequences fetch/decode/execute over one shared ALU and one shared instruction/data memory port.
- Drives imm_src for the sign extender (00 I, 01 S, 10 B, 11 J) plus all datapath muxes and write enables.
- Sits between the instruction register, ALU zero flag, memory handshake and the datapath.

Parameters:
DATA_WIDTH, 32, instruction width.
STATE_WIDTH, 4, width of state encoding and state_dbg.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
instr  in  DATA_WIDTH  instruction register contents; valid from DECODE onward.
zero  in  1  ALU zero flag, same cycle.
mem_ready  in  1  memory completes the current request this cycle.
mem_req  out  1  memory access request.
mem_write  out  1  write qualifier for mem_req.
adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
ir_write  out  1  load instruction register and old PC.
pc_write  out  1  load PC from result mux.
reg_write  out  1  register file write enable.
imm_src  out  2  sign-extender format select.
alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1.
alu_src_b  out  2  00 = rs2, 01 = imm_ext, 10 = constant 4.
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
result_src  out  2  00 = ALU result register, 01 = memory data, 10 = live ALU output.
illegal_instr  out  1  sticky halt flag.
state_dbg  out  STATE_WIDTH  current state encoding.

Behaviour:
- Reset and state register:
  - rst high forces state RESET immediately (async), including mid-access.
  - In RESET every output is 0.
  - RESET moves to FETCH unconditionally on the next clk.
- Outputs not listed for a state are 0.
- Outputs are a combinational decode of the registered state, instr and zero.
- FETCH: mem_req=1, adr_src=0.
  - While mem_ready=0, hold state with mem_req held high.
  - When mem_ready=1: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10. Go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add. This precomputes the branch/jump target.
  - imm_src: 11 if opcode 1101111, else 10.
  - Next state by opcode[6:0]:
    - 0000011 / 0100011 -> MEM_ADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other -> TRAP
- MEM_ADR: alu_src_a=10, alu_src_b=01, add.
  - imm_src: 00 for load, 01 for store.
  - Next: MEM_READ for load, MEM_WRITE for store.
- MEM_READ: mem_req=1, adr_src=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: result_src=01, reg_write=1. Next FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00. Next ALU_WB.
- EXEC_I: alu_src_a=10, alu_src_b=01, imm_src=00. Next ALU_WB.
- ALU decode (funct3 = instr[14:12]):
  - 000 -> add; for R-type with instr[30]=1 -> sub.
  - 111 -> and; 110 -> or; 010 -> slt.
  - Any other funct3 -> TRAP instead of ALU_WB.
- ALU_WB: result_src=00, reg_write=1. Next FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write = zero XOR instr[12]: beq taken on zero=1, bne taken on zero=0.
  - funct3 other than 000/001 -> TRAP with no pc_write.
  - Otherwise next FETCH.
- JAL: pc_write=1, result_src=00 (target from DECODE), alu_src_a=01, alu_src_b=10, add (return address). Next ALU_WB.
- TRAP: illegal_instr=1; state held until rst. No memory, PC or register writes.
- Latencies, counted from the FETCH completion edge:
  - ALU op: 4 cycles.
  - lw: 5 cycles (plus memory wait).
  - sw: 4 cycles (plus memory wait).
  - branch: 3 cycles.
  - jal: 4 cycles.

Test Plan:
- Assert rst mid-MEM_READ with mem_ready=0 -> state_dbg = RESET and all outputs 0 in the same cycle; after release, RESET then FETCH with mem_req=1.
- FETCH with mem_ready low for 3 cycles then high; instr=0x00A00093 (addi x1,x0,10) -> mem_req held 4 cycles; ir_write/pc_write pulse once; EXEC_I shows imm_src=00, alu_src_b=01; ALU_WB shows reg_write=1.
- lw 0x0040A103 then sw 0x0020A223 -> MEM_ADR imm_src 00 then 01; MEM_WB result_src=01 with reg_write=1; MEM_WRITE mem_write=1 until mem_ready.
- beq 0x00208463: zero=1 -> pc_write=1 in BRANCH; repeat with zero=0 -> pc_write=0; bne 0x00209463 with zero=0 -> pc_write=1.
- jal 0x008000EF -> DECODE imm_src=11; JAL asserts pc_write=1 with result_src=00, then ALU_WB reg_write=1.
- R-type sub 0x40208133 -> alu_control=001; instr 0x0000007F or R-type funct3=001 -> TRAP, illegal_instr=1 held for 10+ cycles with no write enables until rst.
